// File: rtl/bitwise_frame_reducer.sv
// Bitwise frame reducer: folds a frame of WIDTH-bit beats into AND / OR / XOR
// summaries plus a beat count, and presents the result until the consumer takes it.
// A frame closes on an accepted beat with in_last set, or when it reaches MAX_BEATS.
module bitwise_frame_reducer #(
   parameter int WIDTH     = 2,
   parameter int MAX_BEATS = 4,
   parameter int CW        = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_and,
   output logic [WIDTH-1:0] out_or,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_beats,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StHold
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc_and;
   logic [WIDTH-1:0] acc_or;
   logic [WIDTH-1:0] acc_xor;
   logic [CW-1:0]    count;

   logic             accept;
   logic             close;
   logic [WIDTH-1:0] nxt_and;
   logic [WIDTH-1:0] nxt_or;
   logic [WIDTH-1:0] nxt_xor;
   logic [CW-1:0]    nxt_count;

   // Post-update accumulator values for the beat on the inputs; the first beat of a
   // frame seeds the accumulators instead of folding into stale contents.
   always_comb begin
      accept = in_valid & in_ready;
      if (state == StIdle) begin
         nxt_and   = data_in;
         nxt_or    = data_in;
         nxt_xor   = data_in;
         nxt_count = CW'(1);
      end else begin
         nxt_and   = acc_and & data_in;
         nxt_or    = acc_or | data_in;
         nxt_xor   = acc_xor ^ data_in;
         nxt_count = count + CW'(1);
      end
      // in_last and the count limit are OR-ed, so hitting both closes just once.
      close = accept & (in_last | (nxt_count == CW'(MAX_BEATS)));
   end

   // Frame state machine: accumulators, registered result fields and handshakes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         acc_and   <= '0;
         acc_or    <= '0;
         acc_xor   <= '0;
         count     <= '0;
         out_and   <= '0;
         out_or    <= '0;
         out_xor   <= '0;
         out_beats <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StAccum: begin
               // in_ready comes up on the first edge after reset and stays up until close.
               in_ready <= 1'b1;
               if (accept) begin
                  acc_and <= nxt_and;
                  acc_or  <= nxt_or;
                  acc_xor <= nxt_xor;
                  count   <= nxt_count;
                  if (close) begin
                     out_and   <= nxt_and;
                     out_or    <= nxt_or;
                     out_xor   <= nxt_xor;
                     out_beats <= nxt_count;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     state     <= StHold;
                  end else begin
                     state <= StAccum;
                  end
               end
            end
            StHold: begin
               // Release leaves a one-cycle bubble: in_ready rises only after the edge.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  count     <= '0;
                  state     <= StIdle;
               end
            end
            default: begin
               state     <= StIdle;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               count     <= '0;
            end
         endcase
      end
   end

   assign out_parity = ^out_xor;

endmodule

// File: tb/tb_bitwise_frame_reducer.sv
// Self-checking bench for bitwise_frame_reducer: directed cases followed by random
// frames, each compared against a fold over the queue of beats sent.
module tb_bitwise_frame_reducer;

   localparam int WIDTH     = 2;
   localparam int MAX_BEATS = 4;
   localparam int CW        = $clog2(MAX_BEATS + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [WIDTH-1:0] out_and;
   logic [WIDTH-1:0] out_or;
   logic [WIDTH-1:0] out_xor;
   logic             out_parity;
   logic [CW-1:0]    out_beats;
   logic             out_valid;
   logic             out_ready;

   int passed = 0;
   int total  = 0;

   logic [WIDTH-1:0] beats[$];

   bitwise_frame_reducer #(
      .WIDTH(WIDTH),
      .MAX_BEATS(MAX_BEATS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_in(data_in),
      .in_valid(in_valid),
      .in_last(in_last),
      .in_ready(in_ready),
      .out_and(out_and),
      .out_or(out_or),
      .out_xor(out_xor),
      .out_parity(out_parity),
      .out_beats(out_beats),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_and"}, 64'(out_and), 64'd0);
      check({tag, "_or"}, 64'(out_or), 64'd0);
      check({tag, "_xor"}, 64'(out_xor), 64'd0);
      check({tag, "_par"}, 64'(out_parity), 64'd0);
      check({tag, "_beats"}, 64'(out_beats), 64'd0);
   endtask

   // Reference: fold the whole frame queue with plain bitwise operators.
   task automatic expect_result(input string tag);
      logic [WIDTH-1:0] e_and;
      logic [WIDTH-1:0] e_or;
      logic [WIDTH-1:0] e_xor;
      e_and = '1;
      e_or  = '0;
      e_xor = '0;
      foreach (beats[i]) begin
         e_and = e_and & beats[i];
         e_or  = e_or | beats[i];
         e_xor = e_xor ^ beats[i];
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_and"}, 64'(out_and), 64'(e_and));
      check({tag, "_or"}, 64'(out_or), 64'(e_or));
      check({tag, "_xor"}, 64'(out_xor), 64'(e_xor));
      check({tag, "_par"}, 64'(out_parity), 64'(^e_xor));
      check({tag, "_beats"}, 64'(out_beats), 64'(beats.size()));
   endtask

   // Sends the queued beats starting and ending on a falling edge; optional idle gaps
   // carry a random in_last that must be ignored.
   task automatic drive_frame(input string tag, input bit use_last, input bit gaps);
      for (int i = 0; i < beats.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_last  = 1'($urandom_range(0, 1));
               data_in  = WIDTH'($urandom);
               @(posedge clk);
               @(negedge clk);
               check({tag, "_gap_valid"}, 64'(out_valid), 64'd0);
            end
         end
         in_valid = 1'b1;
         data_in  = beats[i];
         in_last  = use_last && (i == beats.size() - 1);
         check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
         check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_result(tag);
   endtask

   // Stalls the consumer, offering junk beats that must not be taken, then releases.
   task automatic release_result(input string tag, input int hold);
      in_valid  = 1'b1;
      in_last   = 1'($urandom_range(0, 1));
      data_in   = WIDTH'($urandom);
      out_ready = 1'b0;
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         expect_result({tag, "_hold"});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_rel_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      rst       = 1'b1;
      data_in   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 64'(in_ready), 64'd1);
      check("post_reset_valid", 64'(out_valid), 64'd0);

      // Full-length frame closed by the count limit.
      beats = '{2'b11, 2'b01, 2'b11, 2'b01};
      drive_frame("max4", 1'b0, 1'b0);
      check("max4_and_const", 64'(out_and), 64'h1);
      check("max4_or_const", 64'(out_or), 64'h3);
      check("max4_xor_const", 64'(out_xor), 64'h0);
      release_result("max4", 0);

      // Two beats closed by in_last.
      beats = '{2'b10, 2'b01};
      drive_frame("two", 1'b1, 1'b0);
      check("two_xor_const", 64'(out_xor), 64'h3);
      release_result("two", 0);

      // Single-beat frame, then a five-cycle consumer stall with in_valid high.
      beats = '{2'b10};
      drive_frame("one", 1'b1, 1'b0);
      check("one_par_const", 64'(out_parity), 64'd1);
      release_result("one", 5);

      // in_last coinciding with the count limit: exactly one result.
      beats = '{2'b01, 2'b11, 2'b10, 2'b11};
      drive_frame("last_max", 1'b1, 1'b0);
      release_result("last_max", 1);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("last_max_no_dup", 64'(out_valid), 64'd0);
      end
      beats = '{2'b01, 2'b01};
      drive_frame("after_max", 1'b1, 1'b0);
      release_result("after_max", 0);

      // Reset after two beats of an open frame.
      in_valid = 1'b1;
      in_last  = 1'b0;
      data_in  = 2'b01;
      @(posedge clk);
      @(negedge clk);
      data_in = 2'b10;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      beats = '{2'b11};
      drive_frame("after_rst", 1'b1, 1'b0);
      // Reset while the result is held: it must vanish and never come back.
      rst = 1'b1;
      #1;
      check_all_zero("hold_rst");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_rst_quiet", 64'(out_valid), 64'd0);
      end

      // Random frames with idle gaps and random consumer stalls.
      for (int f = 0; f < 25; f++) begin
         int n;
         bit use_last;
         n = $urandom_range(1, MAX_BEATS);
         use_last = (n < MAX_BEATS) ? 1'b1 : 1'($urandom_range(0, 1));
         beats.delete();
         for (int b = 0; b < n; b++) beats.push_back(WIDTH'($urandom));
         drive_frame("rand", use_last, 1'b1);
         release_result("rand", $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bitwise_frame_reducer.md
BITWISE_FRAME_REDUCER -- requirements
Module: bitwise_frame_reducer

Interface
REQ-001 SHALL have parameter WIDTH, default 2, bit width of each input beat (legal 1..64).
REQ-002 SHALL have parameter MAX_BEATS, default 4, maximum number of beats per frame (legal 2..256).
REQ-003 SHALL have parameter CW, default $clog2(MAX_BEATS+1), width of the beat-count output.
REQ-004 clk  input  1  single clock for all state; rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 data_in  input  WIDTH  input beat.
REQ-007 in_valid  input  1  data_in is valid.
REQ-008 in_last  input  1  beat closes the frame early; qualified by in_valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 out_and  output  WIDTH  bitwise AND of all frame beats.
REQ-011 out_or  output  WIDTH  bitwise OR of all frame beats.
REQ-012 out_xor  output  WIDTH  bitwise XOR of all frame beats.
REQ-013 out_parity  output  1  XOR-reduction of out_xor.
REQ-014 out_beats  output  CW  number of beats in the frame.
REQ-015 out_valid  output  1  result fields are valid.
REQ-016 out_ready  input  1  consumer accepts the result.

Function
REQ-017 SHALL treat a beat as accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-018 SHALL implement states IDLE (no partial frame), ACCUM (frame open), and HOLD (result presented).
REQ-019 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in HOLD.
REQ-020 SHALL drive out_valid = 1 only in HOLD.
REQ-021 On a beat accepted in IDLE, SHALL load acc_and = acc_or = acc_xor = data_in and set count = 1.
REQ-022 On a beat accepted in ACCUM, SHALL update acc_and &= data_in, acc_or |= data_in, acc_xor ^= data_in, and count += 1.
REQ-023 SHALL close the frame on the accepted beat where in_last = 1 or where the post-update count equals MAX_BEATS.
REQ-024 On frame close, SHALL register the results into the out_* fields and enter HOLD on the next cycle.
REQ-025 Latency: out_valid SHALL rise exactly one cycle after the closing beat is accepted.
REQ-026 A single-beat frame (in_last on the first beat) SHALL yield out_and = out_or = out_xor = data_in and out_beats = 1.
REQ-027 If in_last = 1 and count reaches MAX_BEATS on the same beat, SHALL close the frame exactly once.
REQ-028 The out_* fields SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-029 In HOLD with out_ready = 1, SHALL return to IDLE on the next edge and deassert out_valid.
REQ-030 SHALL not accept a beat in the same cycle as the HOLD release; the block has a one-cycle bubble.
REQ-031 The count SHALL never wrap; a frame always closes at MAX_BEATS.
REQ-032 With in_valid = 0 in ACCUM, SHALL hold all accumulators and the count unchanged (no timeout).
REQ-033 in_last SHALL be ignored when in_valid = 0.
REQ-034 out_parity SHALL be combinationally equal to ^out_xor.

Reset
REQ-035 While rst = 1, SHALL immediately force state IDLE and count = 0, independent of clk.
REQ-036 While rst = 1, SHALL force out_valid = 0, in_ready = 0, out_and = out_or = out_xor = 0, out_parity = 0, and out_beats = 0.
REQ-037 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result, with no output afterwards.
REQ-038 After rst deasserts, in_ready SHALL be 1 from the first clk edge.

Verification
REQ-039 WIDTH=2, MAX_BEATS=4; beats 2'b11, 2'b01, 2'b11, 2'b01, no in_last -> out_and=01, out_or=11, out_xor=00, out_parity=0, out_beats=4, out_valid one cycle after the 4th beat.
REQ-040 Beats 2'b10 then 2'b01 with in_last -> out_and=00, out_or=11, out_xor=11, out_parity=0, out_beats=2.
REQ-041 Single beat 2'b10 with in_last -> out_and=out_or=out_xor=10, out_parity=1, out_beats=1.
REQ-042 Hold out_ready=0 for 5 cycles while in_valid=1 -> out_* stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE next cycle, then the next frame starts.
REQ-043 Assert rst after 2 beats of a frame -> all outputs 0 immediately; the next 1-beat frame with in_last reports out_beats=1.
REQ-044 in_last on the 4th beat with MAX_BEATS=4 -> exactly one result, out_beats=4; the following beat starts a new frame.
